adxl362_spi_master: RTL and testbench

Host-side SPI initiator for the PmodACL2 ADXL362 accelerometer. It converts single-command requests from the host logic (register write, register read/burst read, FIFO read) into ADXL362 SPI frames on SCLK/MOSI/nCS, and returns captured MISO bytes on a valid-strobed byte stream. It uses SPI mode 0 (CPOL=0, CPHA=0), MSB first, and processes one command at a time.

---
 rtl/adxl362_spi_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_adxl362_spi_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl362_spi_master.sv
// SPI mode-0 initiator for the ADXL362: turns write / read / FIFO-read commands into
// framed SCLK/MOSI/nCS traffic and streams captured MISO data bytes back to the host.
module adxl362_spi_master #(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic [3:0] cmd_len,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       cmd_err,
    output logic       busy,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       nCS
);

    typedef enum logic [1:0] {
        CMD_WR   = 2'b00,
        CMD_RD   = 2'b01,
        CMD_FIFO = 2'b10,
        CMD_RSV  = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [4:0] byte_q, byte_d;
    logic [4:0] last_q, last_d;
    logic [4:0] dstart_q, dstart_d;
    logic [1:0] typ_q, typ_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] shift_q, shift_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       ncs_q, ncs_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [7:0] tx_cur, tx_next, tx_first;
    logic [4:0] byte_inc;

    // Byte idx of the outgoing frame: instruction, then address / write data, then dummies.
    function automatic logic [7:0] tx_byte(input logic [1:0] t, input logic [7:0] a,
                                           input logic [7:0] w, input logic [4:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx == 5'd0) begin
            case (t)
                CMD_WR:  b = 8'h0A;
                CMD_RD:  b = 8'h0B;
                default: b = 8'h0D;
            endcase
        end else if (idx == 5'd1 && t != CMD_FIFO) begin
            b = a;
        end else if (idx == 5'd2 && t == CMD_WR) begin
            b = w;
        end
        return b;
    endfunction

    assign byte_inc = byte_q + 5'd1;
    assign tx_cur   = tx_byte(typ_q, addr_q, wdata_q, byte_q);
    assign tx_next  = tx_byte(typ_q, addr_q, wdata_q, byte_inc);
    assign tx_first = tx_byte(cmd_type, cmd_addr, cmd_wdata, 5'd0);

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        last_d     = last_q;
        dstart_d   = dstart_q;
        typ_d      = typ_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        shift_d    = shift_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ncs_d      = ncs_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ncs_d  = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (cmd_valid) begin
                    typ_d   = cmd_type;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cnt_d   = 8'd0;
                    bit_d   = 3'd7;
                    byte_d  = 5'd0;
                    shift_d = 8'h00;
                    case (cmd_type)
                        CMD_WR:   begin last_d = 5'd2;                   dstart_d = 5'd1; end
                        CMD_RD:   begin last_d = {1'b0, cmd_len} + 5'd2; dstart_d = 5'd2; end
                        default:  begin last_d = {1'b0, cmd_len} + 5'd1; dstart_d = 5'd1; end
                    endcase
                    if (cmd_type == CMD_RSV) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        ncs_d   = 1'b0;
                        mosi_d  = tx_first[7];
                    end
                end
            end

            S_ERR: state_d = S_IDLE;

            S_SETUP: begin
                if (cnt_q == 8'(CS_SETUP - 1)) begin
                    state_d = S_SHIFT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_SHIFT: begin
                if (cnt_q == 8'(CLK_DIV - 1)) begin
                    cnt_d  = 8'd0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        shift_d = {shift_q[6:0], MISO};
                        if (bit_q == 3'd0 && byte_q >= dstart_q && typ_q != CMD_WR) begin
                            rd_data_d  = {shift_q[6:0], MISO};
                            rd_valid_d = 1'b1;
                        end
                    end else if (bit_q == 3'd0) begin
                        if (byte_q == last_q) begin
                            state_d = S_HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            byte_d = byte_inc;
                            bit_d  = 3'd7;
                            mosi_d = tx_next[7];
                        end
                    end else begin
                        bit_d  = bit_q - 3'd1;
                        mosi_d = tx_cur[bit_q - 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_HOLD: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (cnt_q == 8'(CS_HOLD - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = 8'd0;
                    ncs_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_GAP: begin
                if (cnt_q == 8'(CS_IDLE - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 3'd0;
            byte_q     <= 5'd0;
            last_q     <= 5'd0;
            dstart_q   <= 5'd0;
            typ_q      <= 2'b00;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            shift_q    <= 8'h00;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ncs_q      <= 1'b1;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            dstart_q   <= dstart_d;
            typ_q      <= typ_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            shift_q    <= shift_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ncs_q      <= ncs_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = ~cmd_ready;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;
    assign nCS       = ncs_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_adxl362_spi_master.sv
// Directed bench for adxl362_spi_master with a behavioural ADXL362 SPI slave model.
module tb_adxl362_spi_master;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_IDLE  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_type = 2'b00;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic [3:0] cmd_len = 4'd0;
    logic [7:0] rd_data;
    logic       rd_valid, done, cmd_err, busy;
    logic       SCLK, MOSI, nCS;
    logic       MISO = 1'b0;

    adxl362_spi_master #(
        .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .cmd_err(cmd_err), .busy(busy),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .nCS(nCS)
    );

    always #5 clk = ~clk;

    // ADXL362 slave model: register file, FIFO contents, and per-frame MOSI capture.
    logic [7:0] mem  [0:255];
    logic [7:0] fifo [0:15];
    logic [7:0] mosi_bytes [0:31];
    logic [7:0] in_sr = 8'h00;
    logic [7:0] instr = 8'h00;
    logic [7:0] maddr = 8'h00;
    int         bitc  = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) fifo[i] = 8'h00;
        mem[8'h00] = 8'hAD; mem[8'h01] = 8'h1D; mem[8'h02] = 8'hF2;
        mem[8'h0E] = 8'h34; mem[8'h0F] = 8'h12; mem[8'h10] = 8'hFE;
        mem[8'h11] = 8'hFF; mem[8'h12] = 8'h41; mem[8'h13] = 8'h04;
        fifo[0] = 8'h7A; fifo[1] = 8'h81;
    end

    function automatic logic [7:0] resp_byte(input int idx);
        if (instr == 8'h0B && idx >= 2) return mem[(int'(maddr) + idx - 2) & 255];
        if (instr == 8'h0D && idx >= 1) return fifo[(idx - 1) & 15];
        return 8'h00;
    endfunction

    always @(negedge nCS or posedge SCLK) begin
        if (!nCS && SCLK) begin
            in_sr = {in_sr[6:0], MOSI};
            bitc  = bitc + 1;
            if (bitc % 8 == 0 && bitc <= 256) begin
                mosi_bytes[(bitc / 8 - 1) & 31] = in_sr;
                if (bitc == 8)  instr = in_sr;
                if (bitc == 16) maddr = in_sr;
            end
        end else if (!nCS) begin
            bitc = 0;
        end
    end

    always @(negedge SCLK) begin
        if (!nCS) begin
            logic [7:0] b;
            b    = resp_byte(bitc / 8);
            MISO = b[7 - (bitc % 8)];
        end
    end

    // Event monitor, sampled on the falling clk edge.
    logic [7:0] rd_log [0:63];
    int rv_cnt = 0, done_cnt = 0, err_cnt = 0, low_cnt = 0, fall_cnt = 0;
    int high_run = 0, last_gap = 0;
    logic prev_ncs = 1'b1;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            rd_log[rv_cnt & 63] = rd_data;
            rv_cnt = rv_cnt + 1;
        end
        if (done === 1'b1)    done_cnt = done_cnt + 1;
        if (cmd_err === 1'b1) err_cnt  = err_cnt + 1;
        if (nCS === 1'b0)     low_cnt  = low_cnt + 1;
        if (nCS === 1'b0 && prev_ncs === 1'b1) begin
            last_gap = high_run;
            fall_cnt = fall_cnt + 1;
        end
        high_run = (nCS === 1'b1) ? high_run + 1 : 0;
        prev_ncs = nCS;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic issue(input logic [1:0] t, input logic [7:0] a, input logic [7:0] w,
                         input logic [3:0] l);
        int n = 0;
        @(negedge clk);
        cmd_type = t; cmd_addr = a; cmd_wdata = w; cmd_len = l; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 2000), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr = 8'hFF; cmd_wdata = 8'hFF; cmd_len = 4'hF; cmd_type = 2'b11;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_timeout"}, 32'(n < 5000), 32'd1);
        check({tag, "_ncs_at_done"}, 32'(nCS), 32'd1);
        check({tag, "_err_at_done"}, 32'(cmd_err), 32'd0);
    endtask

    initial begin
        int rv0, dn0, er0, lo0, fa0, n;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ncs", 32'(nCS), 32'd1);
        check("rst_sclk", 32'(SCLK), 32'd0);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdv", 32'(rd_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rd_data), 32'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Register write 0x2D <= 0x02
        rv0 = rv_cnt; dn0 = done_cnt; er0 = err_cnt; lo0 = low_cnt;
        issue(2'b00, 8'h2D, 8'h02, 4'd0);
        check("wr_busy", 32'(busy), 32'd1);
        wait_done("wr");
        wait_ready();
        check("wr_b0", 32'(mosi_bytes[0]), 32'h0A);
        check("wr_b1", 32'(mosi_bytes[1]), 32'h2D);
        check("wr_b2", 32'(mosi_bytes[2]), 32'h02);
        check("wr_sclk_rises", 32'(bitc), 32'd24);
        check("wr_ncs_low", 32'(low_cnt - lo0), 32'd104);
        check("wr_done_cnt", 32'(done_cnt - dn0), 32'd1);
        check("wr_err_cnt", 32'(err_cnt - er0), 32'd0);
        check("wr_rdv_cnt", 32'(rv_cnt - rv0), 32'd0);

        // Single register read of DEVID_AD
        rv0 = rv_cnt; lo0 = low_cnt;
        issue(2'b01, 8'h00, 8'h00, 4'd0);
        wait_done("rd");
        wait_ready();
        check("rd_b0", 32'(mosi_bytes[0]), 32'h0B);
        check("rd_b1", 32'(mosi_bytes[1]), 32'h00);
        check("rd_b2", 32'(mosi_bytes[2]), 32'h00);
        check("rd_sclk_rises", 32'(bitc), 32'd24);
        check("rd_ncs_low", 32'(low_cnt - lo0), 32'd104);
        check("rd_rdv_cnt", 32'(rv_cnt - rv0), 32'd1);
        check("rd_data0", 32'(rd_log[rv0 & 63]), 32'hAD);

        // Burst read XDATA_L..ZDATA_H
        rv0 = rv_cnt; lo0 = low_cnt;
        issue(2'b01, 8'h0E, 8'h00, 4'd5);
        wait_done("burst");
        wait_ready();
        check("burst_b0", 32'(mosi_bytes[0]), 32'h0B);
        check("burst_b1", 32'(mosi_bytes[1]), 32'h0E);
        check("burst_b7", 32'(mosi_bytes[7]), 32'h00);
        check("burst_sclk_rises", 32'(bitc), 32'd64);
        check("burst_ncs_low", 32'(low_cnt - lo0), 32'd264);
        check("burst_rdv_cnt", 32'(rv_cnt - rv0), 32'd6);
        check("burst_x_l", 32'(rd_log[(rv0 + 0) & 63]), 32'h34);
        check("burst_x_h", 32'(rd_log[(rv0 + 1) & 63]), 32'h12);
        check("burst_y_l", 32'(rd_log[(rv0 + 2) & 63]), 32'hFE);
        check("burst_y_h", 32'(rd_log[(rv0 + 3) & 63]), 32'hFF);
        check("burst_z_l", 32'(rd_log[(rv0 + 4) & 63]), 32'h41);
        check("burst_z_h", 32'(rd_log[(rv0 + 5) & 63]), 32'h04);

        // FIFO read, two bytes
        rv0 = rv_cnt;
        issue(2'b10, 8'h55, 8'h00, 4'd1);
        wait_done("fifo");
        wait_ready();
        check("fifo_b0", 32'(mosi_bytes[0]), 32'h0D);
        check("fifo_sclk_rises", 32'(bitc), 32'd24);
        check("fifo_rdv_cnt", 32'(rv_cnt - rv0), 32'd2);
        check("fifo_d0", 32'(rd_log[(rv0 + 0) & 63]), 32'h7A);
        check("fifo_d1", 32'(rd_log[(rv0 + 1) & 63]), 32'h81);

        // Reset during the second byte of a write
        dn0 = done_cnt; rv0 = rv_cnt;
        issue(2'b00, 8'h2D, 8'h02, 4'd0);
        n = 0;
        while (bitc < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reach_timeout", 32'(n < 2000), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ncs", 32'(nCS), 32'd1);
        check("mid_rst_sclk", 32'(SCLK), 32'd0);
        check("mid_rst_mosi", 32'(MOSI), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - dn0), 32'd0);
        check("mid_rst_no_rdv", 32'(rv_cnt - rv0), 32'd0);
        rv0 = rv_cnt;
        issue(2'b01, 8'h00, 8'h00, 4'd0);
        wait_done("post_rst_rd");
        wait_ready();
        check("post_rst_rdv_cnt", 32'(rv_cnt - rv0), 32'd1);
        check("post_rst_data", 32'(rd_log[rv0 & 63]), 32'hAD);

        // cmd_valid held high across two reads
        rv0 = rv_cnt; fa0 = fall_cnt;
        @(negedge clk);
        cmd_type = 2'b01; cmd_addr = 8'h00; cmd_len = 4'd0; cmd_valid = 1'b1;
        n = 0;
        while (fall_cnt < fa0 + 2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        check("b2b_accept_timeout", 32'(n < 5000), 32'd1);
        check("b2b_gap_min", 32'(last_gap >= CS_IDLE), 32'd1);
        wait_done("b2b");
        wait_ready();
        check("b2b_rdv_cnt", 32'(rv_cnt - rv0), 32'd2);
        check("b2b_data0", 32'(rd_log[(rv0 + 0) & 63]), 32'hAD);
        check("b2b_data1", 32'(rd_log[(rv0 + 1) & 63]), 32'hAD);

        // Reserved command type
        fa0 = fall_cnt; dn0 = done_cnt; er0 = err_cnt;
        @(negedge clk);
        cmd_type = 2'b11; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rsv_done", 32'(done), 32'd1);
        check("rsv_err", 32'(cmd_err), 32'd1);
        check("rsv_ncs", 32'(nCS), 32'd1);
        check("rsv_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("rsv_done_end", 32'(done), 32'd0);
        check("rsv_err_end", 32'(cmd_err), 32'd0);
        check("rsv_ready_back", 32'(cmd_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("rsv_no_ncs_fall", 32'(fall_cnt - fa0), 32'd0);
        check("rsv_done_cnt", 32'(done_cnt - dn0), 32'd1);
        check("rsv_err_cnt", 32'(err_cnt - er0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
